// File: rtl/acc_pkg.sv
// Shared types and helpers for the accumulation sequencer (acc_ctrl).
package acc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Frames-per-accumulation value substituted when acc_len is 0.
  localparam int unsigned ACC_LEN_ZERO_MAP = 1;

  function automatic int unsigned chan_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/acc_ctrl_cnt.sv
// Wrapping counter. cnt is the index of the word being processed this cycle
// (forced to 0 by clr); tc flags that this word carries the last index.
module acc_ctrl_cnt #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt = clr ? '0 : cnt_q;
  assign tc  = (cnt == last);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tc ? '0 : cnt + W'(1);
    end else if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acc_ctrl.sv
// Sequencer feeding the band DoA accumulators: counts channels/frames and emits
// registered din/valid/acc_done/chan_idx/dump_en. Option: ACC_CTRL_SKIP_FIRST_EN.
module acc_ctrl
  import acc_pkg::*;
#(
  parameter int unsigned DIN_WIDTH     = 16,
  parameter int unsigned VEC_LEN       = 64,
  parameter int unsigned ACC_LEN_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sync_in,
  input  logic signed [DIN_WIDTH-1:0]       din,
  input  logic                              din_valid,
  input  logic [ACC_LEN_WIDTH-1:0]          acc_len,
  output logic signed [DIN_WIDTH-1:0]       dout,
  output logic                              dout_valid,
  output logic                              acc_done,
  output logic [chan_w(VEC_LEN)-1:0]        chan_idx,
  output logic                              dump_en,
  output logic                              armed
);

  localparam int unsigned CW = chan_w(VEC_LEN);
  localparam int unsigned AW = ACC_LEN_WIDTH;
  localparam logic [CW-1:0] CHAN_LAST = CW'(VEC_LEN - 1);

  state_e state_q, state_d;

  logic          start, active, load;
  logic [CW-1:0] chan_cur;
  logic          chan_tc;
  logic [AW-1:0] frame_cur, frame_last, len_eff, len_r_q, len_r_d;
  logic          frame_tc;

  logic signed [DIN_WIDTH-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          acc_done_q, acc_done_d;
  logic [CW-1:0] chan_idx_q, chan_idx_d;
  logic          dump_en_q, dump_en_d;

`ifdef ACC_CTRL_SKIP_FIRST_EN
  logic skip_q, skip_d, skip_cur;
  logic bound_q, bound_d;
`endif

  always_comb begin
    start   = sync_in & din_valid;
    active  = din_valid & ((state_q == RUN) | sync_in);
    len_eff = (acc_len == '0) ? AW'(ACC_LEN_ZERO_MAP) : acc_len;
  end

  // The frame modulus must already be the new length on the word that loads it,
  // otherwise a 1-frame accumulation would run with the stale length.
  always_comb begin
    load       = start | (active & (chan_cur == '0) & (frame_cur == '0));
    len_r_d    = load ? len_eff : len_r_q;
    frame_last = len_r_d - AW'(1);
  end

  acc_ctrl_cnt #(.W(CW)) u_chan_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (active),
    .clr   (start),
    .last  (CHAN_LAST),
    .cnt   (chan_cur),
    .tc    (chan_tc)
  );

  acc_ctrl_cnt #(.W(AW)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (active & chan_tc),
    .clr   (start),
    .last  (frame_last),
    .cnt   (frame_cur),
    .tc    (frame_tc)
  );

  always_comb begin
    state_d      = state_q;
    if (start) begin
      state_d = RUN;
    end
    dout_d       = din;
    dout_valid_d = active;
    acc_done_d   = active & (frame_cur == '0);
    chan_idx_d   = active ? chan_cur : chan_idx_q;
`ifdef ACC_CTRL_SKIP_FIRST_EN
    // bound_q: the next word would start an accumulation on its own.
    skip_cur  = start ? ((state_q == IDLE) | ~bound_q) : skip_q;
    dump_en_d = acc_done_d & ~skip_cur;
    skip_d    = active ? (skip_cur & ~chan_tc) : skip_q;
    bound_d   = active ? (chan_tc & frame_tc) : bound_q;
`else
    dump_en_d = acc_done_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_r_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      acc_done_q   <= 1'b0;
      chan_idx_q   <= '0;
      dump_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_r_q      <= len_r_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      acc_done_q   <= acc_done_d;
      chan_idx_q   <= chan_idx_d;
      dump_en_q    <= dump_en_d;
    end
  end

`ifdef ACC_CTRL_SKIP_FIRST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_q  <= 1'b0;
      bound_q <= 1'b0;
    end else begin
      skip_q  <= skip_d;
      bound_q <= bound_d;
    end
  end
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign acc_done   = acc_done_q;
  assign chan_idx   = chan_idx_q;
  assign dump_en    = dump_en_q;
  assign armed      = (state_q == RUN);

endmodule

// File: tb/tb_acc_ctrl.sv
// Scoreboard bench for acc_ctrl with VEC_LEN=4; honours ACC_CTRL_SKIP_FIRST_EN.
module tb_acc_ctrl;

`ifdef ACC_CTRL_SKIP_FIRST_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sync_in = 1'b0;
  logic               din_valid = 1'b0;
  logic signed [15:0] din = '0;
  logic [15:0]        acc_len = 16'd3;
  logic signed [15:0] dout;
  logic               dout_valid, acc_done, dump_en, armed;
  logic [1:0]         chan_idx;

  typedef struct packed {
    logic [15:0] d;
    logic        done;
    logic [1:0]  ch;
    logic        dump;
    logic        arm;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nfail = 0;
  logic [15:0] dval = 16'h1000;

  acc_ctrl #(.DIN_WIDTH(16), .VEC_LEN(4), .ACC_LEN_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_in    (sync_in),
    .din        (din),
    .din_valid  (din_valid),
    .acc_len    (acc_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .acc_done   (acc_done),
    .chan_idx   (chan_idx),
    .dump_en    (dump_en),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One input word; ex=1 means an output word is expected one cycle later.
  task automatic send(input logic s, input logic v, input logic ex, input logic e_done,
                      input int e_ch, input logic skip, input logic [15:0] len);
    exp_t e;
    @(posedge clk);
    #1;
    dval      = dval + 16'h0123;
    sync_in   = s;
    din_valid = v;
    din       = dval;
    acc_len   = len;
    if (ex) begin
      e.d    = dval;
      e.done = e_done;
      e.ch   = 2'(e_ch);
      e.dump = e_done & ~(skip & SKIP_EN);
      e.arm  = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      sync_in   = 1'b0;
      din_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dout_valid) begin
      nvec++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_output: got dout_valid=1 chan=%0d expected no output", chan_idx);
      end else begin
        e = sb.pop_front();
        if ({dout, acc_done, chan_idx, dump_en, armed} !== e) begin
          nfail++;
          $display("FAIL out_word: got dout=%h done=%b ch=%0d dump=%b armed=%b expected dout=%h done=%b ch=%0d dump=%b armed=%b",
                   dout, acc_done, chan_idx, dump_en, armed, e.d, e.done, e.ch, e.dump, e.arm);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_acc_done", 32'(acc_done), 0);
    chk("rst_chan_idx", 32'(chan_idx), 0);
    chk("rst_armed", 32'(armed), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // words before any sync, and a sync without valid, are dropped
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd3);
    send(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 16'd3);
    idle(2);
    @(negedge clk);
    chk("presync_armed", 32'(armed), 0);

    // acc_len=3, continuous: done on words 0-3, 12-15, 24-27
    for (int k = 0; k < 36; k++)
      send(k == 0, 1'b1, 1'b1, ((k / 4) % 3) == 0, k % 4, k < 4, 16'd3);

    // acc_len=2 with gaps: done on valid words 0-3, 8-11
    for (int j = 0; j < 16; j++) begin
      send(1'b0, 1'b1, 1'b1, ((j / 4) % 2) == 0, j % 4, 1'b0, 16'd2);
      send(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 16'd2);
    end

    // acc_len 3 -> 5 mid-accumulation: done on 0-3, 12-15, 32-35
    for (int k = 0; k < 36; k++)
      send(1'b0, 1'b1, 1'b1, (k < 4) || (k >= 12 && k < 16) || (k >= 32),
           k % 4, 1'b0, (k < 4) ? 16'd3 : 16'd5);

    // frame 1 chan 0,1 then resync at chan 2 with acc_len=2
    send(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 16'd5);
    send(1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0, 16'd5);
    for (int r = 0; r < 16; r++)
      send(r == 0, 1'b1, 1'b1, ((r / 4) % 2) == 0, r % 4, r < 4, 16'd2);

    // acc_len=0 acts as 1; sync at k=4 lands on a natural boundary
    for (int k = 0; k < 8; k++)
      send(k == 4, 1'b1, 1'b1, 1'b1, k % 4, 1'b0, 16'd0);

    // asynchronous reset mid-frame
    send(1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 16'd0);
    send(1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 16'd0);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    sync_in   = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("midrst_dout", 32'(dout), 0);
    chk("midrst_dout_valid", 32'(dout_valid), 0);
    chk("midrst_acc_done", 32'(acc_done), 0);
    chk("midrst_chan_idx", 32'(chan_idx), 0);
    chk("midrst_dump_en", 32'(dump_en), 0);
    chk("midrst_armed", 32'(armed), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 2; i++) send(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0);
    idle(2);
    @(negedge clk);
    chk("postrst_armed", 32'(armed), 0);
    send(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 16'd0);
    send(1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b1, 16'd0);
    idle(3);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
